sreg_update_arbiter: RTL and testbench

//  Shares the NZCV status register between two flag producers: req0 = ALU flag-setting ops, req1 = multi-cycle/restore unit.

---
 rtl/sreg_update_arbiter_pkg.sv | 32 +++
 rtl/sreg_update_arbiter_cond_eval.sv | 43 ++++
 rtl/sreg_update_arbiter.sv | 118 +++++++++++
 tb/tb_sreg_update_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sreg_update_arbiter_pkg.sv
// Shared constants for the NZCV status-register arbiter and the B.cond evaluator.
// Holds the condition-code encodings, the flag bit positions and the round-robin pointer type.
package sreg_update_arbiter_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_e;

endpackage

// File: rtl/sreg_update_arbiter_cond_eval.sv
// Combinational LEGv8 B.cond resolver: (flags {N,Z,C,V}, condition code) -> taken.
// Shared with the branch unit, so it carries no state.
module cond_eval
    import sreg_update_arbiter_pkg::*;
#(
    parameter int FLAG_W = 4,
    parameter int COND_W = 4
) (
    input  logic [FLAG_W-1:0] flags,
    input  logic [COND_W-1:0] cond_code,
    output logic              taken
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so every path writes taken and no latch is inferred.
        taken = 1'b1;
        case (cond_code)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c & !z;
            COND_LS: taken = !(c & !z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z & (n == v);
            COND_LE: taken = !(!z & (n == v));
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/sreg_update_arbiter.sv
// Round-robin arbiter sharing the NZCV status register between two flag producers, plus B.cond resolution.
// Build option FLAG_BYPASS_EN: forward in-flight flags to the condition check instead of stalling it.
module sreg_update_arbiter
    import sreg_update_arbiter_pkg::*;
#(
    parameter int FLAG_W   = 4,
    parameter int COND_W   = 4,
    parameter int STALL_CW = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                hold,
    input  logic                req0_valid,
    input  logic [FLAG_W-1:0]   req0_nzcv,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [FLAG_W-1:0]   req1_nzcv,
    output logic                req1_ready,
    output logic                sreg_update,
    output logic [FLAG_W-1:0]   sreg_nzcv,
    input  logic [FLAG_W-1:0]   flags_cur,
    input  logic                cond_valid,
    input  logic [COND_W-1:0]   cond_code,
    output logic                cond_ready,
    output logic                cond_done,
    output logic                cond_taken,
    output logic [STALL_CW-1:0] stall_cnt
);

    rr_e                 rr_ptr_q, rr_ptr_d;
    logic                sreg_update_q, sreg_update_d;
    logic [FLAG_W-1:0]   sreg_nzcv_q, sreg_nzcv_d;
    logic                cond_done_q, cond_done_d;
    logic                cond_taken_q, cond_taken_d;
    logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

    logic              grant0, grant1, grant_any;
    logic [FLAG_W-1:0] grant_nzcv;
    logic [FLAG_W-1:0] eval_flags;
    logic              eval_taken;

    // Contention is resolved by the pointer; a lone requester always wins.
    assign grant0    = !hold & req0_valid & (!req1_valid | (rr_ptr_q == RR_REQ0));
    assign grant1    = !hold & req1_valid & (!req0_valid | (rr_ptr_q == RR_REQ1));
    assign grant_any = grant0 | grant1;
    assign grant_nzcv = grant0 ? req0_nzcv : req1_nzcv;

`ifdef FLAG_BYPASS_EN
    assign cond_ready = cond_valid;
    assign eval_flags = grant_any     ? grant_nzcv  :
                        sreg_update_q ? sreg_nzcv_q : flags_cur;
`else
    // A grant this cycle is older than the branch, so the branch waits until the write lands.
    assign cond_ready = cond_valid & !(grant_any | sreg_update_q);
    assign eval_flags = flags_cur;
`endif

    cond_eval #(
        .FLAG_W (FLAG_W),
        .COND_W (COND_W)
    ) u_cond_eval (
        .flags     (eval_flags),
        .cond_code (cond_code),
        .taken     (eval_taken)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant0) begin
            rr_ptr_d = RR_REQ1;
        end else if (grant1) begin
            rr_ptr_d = RR_REQ0;
        end

        sreg_update_d = grant_any;
        sreg_nzcv_d   = grant_any ? grant_nzcv : sreg_nzcv_q;

        cond_done_d  = cond_ready;
        cond_taken_d = cond_ready ? eval_taken : cond_taken_q;

`ifdef FLAG_BYPASS_EN
        stall_cnt_d = '0;
`else
        stall_cnt_d = stall_cnt_q;
        if (cond_valid && !cond_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CW'(1);
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q      <= RR_REQ0;
            sreg_update_q <= 1'b0;
            sreg_nzcv_q   <= '0;
            cond_done_q   <= 1'b0;
            cond_taken_q  <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            sreg_update_q <= sreg_update_d;
            sreg_nzcv_q   <= sreg_nzcv_d;
            cond_done_q   <= cond_done_d;
            cond_taken_q  <= cond_taken_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign sreg_update = sreg_update_q;
    assign sreg_nzcv   = sreg_nzcv_q;
    assign cond_done   = cond_done_q;
    assign cond_taken  = cond_taken_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_sreg_update_arbiter.sv
// Self-checking bench for sreg_update_arbiter: directed corner cases, a condition-code table sweep and a random run.
// Expectations follow FLAG_BYPASS_EN the same way the design build does.
module tb_sreg_update_arbiter;

    localparam int FLAG_W   = 4;
    localparam int COND_W   = 4;
    localparam int STALL_CW = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                hold;
    logic                req0_valid, req1_valid;
    logic [FLAG_W-1:0]   req0_nzcv, req1_nzcv;
    logic                req0_ready, req1_ready;
    logic                sreg_update;
    logic [FLAG_W-1:0]   sreg_nzcv;
    logic [FLAG_W-1:0]   flags_cur;
    logic                cond_valid;
    logic [COND_W-1:0]   cond_code;
    logic                cond_ready, cond_done, cond_taken;
    logic [STALL_CW-1:0] stall_cnt;

    // Stand-in for the status register, with an override used by the table sweep.
    logic [FLAG_W-1:0] sr_q;
    logic [FLAG_W-1:0] flags_ovr;
    logic              ovr_en;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] code;
        logic [3:0] flags;
        logic       exp_taken;
    } cond_vec_t;

    cond_vec_t vecs [256];

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         sr_q <= '0;
        else if (sreg_update) sr_q <= sreg_nzcv;
    end

    assign flags_cur = ovr_en ? flags_ovr : sr_q;

    sreg_update_arbiter #(
        .FLAG_W   (FLAG_W),
        .COND_W   (COND_W),
        .STALL_CW (STALL_CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hold        (hold),
        .req0_valid  (req0_valid),
        .req0_nzcv   (req0_nzcv),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_nzcv   (req1_nzcv),
        .req1_ready  (req1_ready),
        .sreg_update (sreg_update),
        .sreg_nzcv   (sreg_nzcv),
        .flags_cur   (flags_cur),
        .cond_valid  (cond_valid),
        .cond_code   (cond_code),
        .cond_ready  (cond_ready),
        .cond_done   (cond_done),
        .cond_taken  (cond_taken),
        .stall_cnt   (stall_cnt)
    );

    // Codes pair up as (condition, inverse); 14/15 are always taken.
    function automatic logic ref_taken(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hold       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_nzcv  = '0;
        req1_nzcv  = '0;
        cond_valid = 1'b0;
        cond_code  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          turn, exp_upd, exp_done, exp_taken, g0, g1, want0, want1, busy, accept;
        logic [3:0]  exp_nzcv, mflags, gflags, ef;
        int          exp_stall;

        for (int i = 0; i < 256; i++) begin
            vecs[i].code      = 4'(i >> 4);
            vecs[i].flags     = 4'(i);
            vecs[i].exp_taken = ref_taken(4'(i >> 4), 4'(i));
        end

        ovr_en    = 1'b0;
        flags_ovr = '0;
        idle_inputs();
        reset_n = 1'b0;

        // Reset held: every output at zero.
        step();
        check("rst_upd",   sreg_update, 0);
        check("rst_nzcv",  sreg_nzcv,   0);
        check("rst_done",  cond_done,   0);
        check("rst_taken", cond_taken,  0);
        check("rst_stall", stall_cnt,   0);
        reset_n = 1'b1;
        step();

        // Reset in the middle of a write drops it immediately and reloads the pointer.
        req0_valid = 1'b1; req0_nzcv = 4'hF;
        #1 check("mid_r0rdy", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        check("mid_upd_pre", sreg_update, 1);
        reset_n = 1'b0;
        #1;
        check("mid_upd", sreg_update, 0);
        check("mid_nzcv", sreg_nzcv, 0);
        step();
        reset_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("ptr_rst_r0", req0_ready, 1);
        check("ptr_rst_r1", req1_ready, 0);
        idle_inputs();
        step();

        // Lone req0 write: ready now, pulse next cycle, quiet after.
        req0_valid = 1'b1; req0_nzcv = 4'b0100;
        #1;
        check("t2_r0rdy", req0_ready, 1);
        check("t2_r1rdy", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        check("t2_upd1", sreg_update, 1);
        check("t2_nzcv", sreg_nzcv, 4'b0100);
        step();
        check("t2_upd0", sreg_update, 0);

        // Contention alternates, hold blocks grants and keeps the pointer.
        do_reset();
        req0_valid = 1'b1; req0_nzcv = 4'h1;
        req1_valid = 1'b1; req1_nzcv = 4'h2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_r0rdy", req0_ready, (i % 2) == 0);
            check("t3_r1rdy", req1_ready, (i % 2) == 1);
            step();
            check("t3_upd", sreg_update, 1);
            check("t3_nzcv", sreg_nzcv, ((i % 2) == 0) ? 4'h1 : 4'h2);
        end
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_hold_r0", req0_ready, 0);
            check("t3_hold_r1", req1_ready, 0);
            step();
        end
        check("t3_hold_upd", sreg_update, 0);
        hold = 1'b0;
        #1;
        check("t3_after_r0", req0_ready, 1);
        check("t3_after_r1", req1_ready, 0);
        idle_inputs();
        step();
        step();

        // Grant and B.EQ in the same cycle; flags_cur has Z=0 until the write lands.
        do_reset();
        req0_valid = 1'b1; req0_nzcv = 4'b0100;
        cond_valid = 1'b1; cond_code = 4'h0;
        #1;
        check("t4_r0rdy", req0_ready, 1);
`ifdef FLAG_BYPASS_EN
        check("t4_crdy0", cond_ready, 1);
        step();
        req0_valid = 1'b0;
        cond_valid = 1'b0;
        check("t4_done", cond_done, 1);
        check("t4_taken", cond_taken, 1);
        check("t4_stall", stall_cnt, 0);
`else
        check("t4_crdy0", cond_ready, 0);
        step();
        req0_valid = 1'b0;
        #1;
        check("t4_crdy1", cond_ready, 0);
        check("t4_done1", cond_done, 0);
        step();
        #1;
        check("t4_crdy2", cond_ready, 1);
        step();
        cond_valid = 1'b0;
        check("t4_done", cond_done, 1);
        check("t4_taken", cond_taken, 1);
        check("t4_stall", stall_cnt, 2);
`endif
        step();
        check("t4_done_off", cond_done, 0);

        // Full condition-code x flag sweep with no writes in flight.
        ovr_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            flags_ovr  = vecs[i].flags;
            cond_code  = vecs[i].code;
            cond_valid = 1'b1;
            #1;
            check("t5_rdy", cond_ready, 1);
            step();
            check("t5_done", cond_done, 1);
            if (cond_taken !== vecs[i].exp_taken) begin
                $display("FAIL t5_taken code=%0h flags=%0h: got %0b expected %0b",
                         vecs[i].code, vecs[i].flags, cond_taken, vecs[i].exp_taken);
                bad++;
            end
            total++;
        end
        cond_valid = 1'b0;
        ovr_en     = 1'b0;
        step();

        // Continuous writes starve the branch long enough to saturate the counter.
        req0_valid = 1'b1;
        cond_valid = 1'b1; cond_code = 4'h0;
        for (int i = 0; i < 300; i++) begin
            req0_nzcv = 4'($urandom_range(0, 15));
            step();
        end
`ifdef FLAG_BYPASS_EN
        check("t6_stall", stall_cnt, 0);
`else
        check("t6_stall", stall_cnt, 255);
`endif
        idle_inputs();
        step();
        step();

        // Random traffic against a transaction-level model of the flag register and the branch.
        do_reset();
        turn = 1'b0; exp_upd = 1'b0; exp_nzcv = '0; mflags = '0;
        exp_done = 1'b0; exp_taken = 1'b0; exp_stall = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            check("rnd_upd", sreg_update, exp_upd);
            if (exp_upd) check("rnd_nzcv", sreg_nzcv, exp_nzcv);
            check("rnd_done", cond_done, exp_done);
            check("rnd_taken", cond_taken, exp_taken);
            check("rnd_stall", stall_cnt, exp_stall);

            hold       = ($urandom_range(0, 4) == 0);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_nzcv  = 4'($urandom_range(0, 15));
            req1_nzcv  = 4'($urandom_range(0, 15));
            cond_valid = ($urandom_range(0, 2) != 0);
            cond_code  = 4'($urandom_range(0, 15));
            #1;

            want0 = req0_valid && !hold;
            want1 = req1_valid && !hold;
            g0 = want0 && (!want1 || !turn);
            g1 = want1 && (!want0 || turn);
            gflags = g0 ? req0_nzcv : req1_nzcv;
            busy = g0 || g1 || exp_upd;
`ifdef FLAG_BYPASS_EN
            ef = (g0 || g1) ? gflags : (exp_upd ? exp_nzcv : mflags);
            accept = cond_valid;
`else
            ef = mflags;
            accept = cond_valid && !busy;
`endif
            check("rnd_r0rdy", req0_ready, g0);
            check("rnd_r1rdy", req1_ready, g1);
            check("rnd_crdy", cond_ready, accept);

            if (exp_upd) mflags = exp_nzcv;
            if (g0)      turn = 1'b1;
            else if (g1) turn = 1'b0;
            exp_upd = g0 || g1;
            if (g0 || g1) exp_nzcv = gflags;
            exp_done = accept;
            if (accept) exp_taken = ref_taken(cond_code, ef);
            if (cond_valid && !accept && exp_stall < 255) exp_stall++;
            step();
        end

        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
